// File: rtl/probe_display_mux_pkg.sv
// Shared constants for the probe display multiplexer.
// Segment bytes are {dp,g,f,e,d,c,b,a}. They are active-low, so a 0 bit
// lights that segment.
//   SEG_BLANK   : all segments off
//   SEG_A..SEG_DP : bit position of each segment inside a byte
//   HEX_GLYPH   : standard hex glyphs 0..F with the decimal point off
//   next_index  : scan-order successor of a channel index
package probe_display_mux_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] HEX_GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0,   // 0 1 2 3
    8'h99, 8'h92, 8'h82, 8'hF8,   // 4 5 6 7
    8'h80, 8'h90, 8'h88, 8'h83,   // 8 9 A b
    8'hC6, 8'hA1, 8'h86, 8'h8E    // C d E F
  };

  // Wraps to 0 after the last channel. An index that is already out of
  // range (>= ch) also lands on 0.
  function automatic logic [3:0] next_index(input logic [3:0] idx, input int ch);
    if ({1'b0, idx} >= 5'(ch - 1)) return 4'd0;
    return idx + 4'd1;
  endfunction

endpackage

// File: rtl/probe_display_mux_hex7seg.sv
// Combinational nibble-to-seven-segment decoder.
//   nibble : 4-bit value to show
//   seg    : active-low {dp,g,f,e,d,c,b,a}, decimal point off
module hex7seg
  import probe_display_mux_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  assign seg = HEX_GLYPH[nibble];

endmodule

// File: rtl/probe_display_mux.sv
// Probe display multiplexer. It shows one of CH probe words as hex digits
// on DIG seven-segment displays. A separate display shows the channel index.
// The channel is chosen by a rotary switch or by a timed auto-scan. A
// freeze input latches the word shown at the moment freeze rises.
//   clock          : system clock
//   reset          : synchronous, active-high
//   ch_data        : packed probes, channel k = ch_data[k*W +: W]
//   select_display : manual channel index
//   auto_scan      : 1 = rotate channels every PRESCALE cycles
//   freeze         : 1 = hold the displayed value, index and prescaler
//   seg_out        : digit d = seg_out[d*8 +: 8], digit 0 = least significant nibble
//   index_out      : glyph of the current channel index
//   frozen         : freeze hold is being displayed
module probe_display_mux
  import probe_display_mux_pkg::*;
#(
  parameter  int CH       = 8,
  parameter  int W        = 16,
  parameter  int PRESCALE = 50_000_000,
  localparam int DIG      = W / 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CH*W-1:0]   ch_data,
  input  logic [3:0]        select_display,
  input  logic              auto_scan,
  input  logic              freeze,
  output logic [DIG*8-1:0]  seg_out,
  output logic [7:0]        index_out,
  output logic              frozen
);

  localparam int            PW      = $clog2(PRESCALE);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [3:0]       index_q, index_next;
  logic [PW-1:0]    presc_q, presc_next;
  logic [W-1:0]     snapshot_q;
  logic             freeze_q;
  logic             freeze_rise;
  logic             in_range;
  logic [W-1:0]     live_word;
  logic [W-1:0]     disp_word;
  logic [DIG*8-1:0] digit_seg;
  logic [DIG*8-1:0] seg_next;
  logic [7:0]       index_seg;

  assign freeze_rise = freeze & ~freeze_q;

  // Compute the next index and prescale count. While freeze is high, both
  // values hold. If the prescale terminal count lands on the same cycle that
  // freeze rises, the hold wins and the index does not advance. Leaving auto
  // mode clears the prescaler, so the next entry into auto mode starts a
  // fresh dwell from the current index.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    index_next = index_q;
    presc_next = presc_q;
    if (!auto_scan) begin
      presc_next = '0;
      if (!freeze) index_next = select_display;
    end else if (!freeze) begin
      if (presc_q == PS_LAST) begin
        presc_next = '0;
        index_next = next_index(index_q, CH);
      end else begin
        presc_next = presc_q + PW'(1);
      end
    end
  end

  // Display follows the index value that is being registered this cycle.
  // This gives seg_out a single cycle of latency from the inputs.
  always_comb begin
    live_word = '0;
    for (int k = 0; k < CH; k++) begin
      if (index_next == 4'(k)) live_word = ch_data[k*W +: W];
    end
  end

  assign in_range = ({1'b0, index_next} < 5'(CH));

  // On the rising edge the snapshot register is only being loaded, so the
  // live word is shown directly. That live word is the same value being
  // captured.
  assign disp_word = (freeze && !freeze_rise) ? snapshot_q : live_word;

  for (genvar d = 0; d < DIG; d++) begin : g_digit
    hex7seg u_digit (
      .nibble (disp_word[d*4 +: 4]),
      .seg    (digit_seg[d*8 +: 8])
    );
  end

  hex7seg u_index (
    .nibble (index_next),
    .seg    (index_seg)
  );

  always_comb begin
    seg_next = {DIG{SEG_BLANK}};
    if (freeze) begin
      seg_next         = digit_seg;
      seg_next[SEG_DP] = 1'b0;       // lit dp on digit 0 marks a frozen value
    end else if (in_range) begin
      seg_next = digit_seg;
    end
  end

  // NOTE: state is updated with non-blocking assignments so that every
  // register samples the values from before this edge, whatever order the
  // statements appear in.
  always_ff @(posedge clock) begin
    if (reset) begin
      index_q    <= '0;
      presc_q    <= '0;
      snapshot_q <= '0;
      freeze_q   <= 1'b0;
      seg_out    <= {DIG{SEG_BLANK}};
      index_out  <= SEG_BLANK;
      frozen     <= 1'b0;
    end else begin
      index_q   <= index_next;
      presc_q   <= presc_next;
      freeze_q  <= freeze;
      if (freeze_rise) snapshot_q <= live_word;
      seg_out   <= seg_next;
      index_out <= index_seg;
      frozen    <= freeze;
    end
  end

endmodule

// File: tb/tb_probe_display_mux.sv
module tb_probe_display_mux;

  localparam int CH       = 8;
  localparam int W        = 16;
  localparam int PRESCALE = 4;
  localparam int DIG      = W / 4;

  localparam logic [31:0] BLANK = 32'hFFFF_FFFF;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [CH*W-1:0]   ch_data;
  logic [3:0]        select_display;
  logic              auto_scan;
  logic              freeze;
  logic [DIG*8-1:0]  seg_out;
  logic [7:0]        index_out;
  logic              frozen;

  probe_display_mux #(.CH(CH), .W(W), .PRESCALE(PRESCALE)) dut (
    .clock          (clock),
    .reset          (reset),
    .ch_data        (ch_data),
    .select_display (select_display),
    .auto_scan      (auto_scan),
    .freeze         (freeze),
    .seg_out        (seg_out),
    .index_out      (index_out),
    .frozen         (frozen)
  );

  always #5 clock = ~clock;

  // Hand-written active-low glyphs {dp,g,f,e,d,c,b,a}.
  logic [7:0] glyph [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [31:0] seg_of(input logic [15:0] v, input bit dp_lit);
    logic [31:0] s;
    for (int d = 0; d < 4; d++) s[d*8 +: 8] = glyph[v[d*4 +: 4]];
    if (dp_lit) s[7] = 1'b0;
    return s;
  endfunction

  typedef struct {
    int          cyc;
    logic [31:0] seg;
    logic [7:0]  idx;
    logic        frz;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: each expectation is due on a known cycle and is compared at
  // that cycle's falling edge.
  always @(negedge clock) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_cmp++;
      if (e.cyc != cyc || seg_out !== e.seg || index_out !== e.idx || frozen !== e.frz) begin
        n_fail++;
        $display("FAIL %s @cyc %0d (due %0d): got seg=%h idx=%h frozen=%b, expected seg=%h idx=%h frozen=%b",
                 e.name, cyc, e.cyc, seg_out, index_out, frozen, e.seg, e.idx, e.frz);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int dly, input logic [31:0] seg, input logic [7:0] idx,
                      input logic frz, input string name);
    exp_t e;
    e.cyc  = cyc + dly;
    e.seg  = seg;
    e.idx  = idx;
    e.frz  = frz;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic set_ch(input int k, input logic [15:0] v);
    ch_data[k*W +: W] = v;
  endtask

  initial begin
    ch_data = '0;
    set_ch(0, 16'h0F0F); set_ch(1, 16'h1111); set_ch(2, 16'h1234); set_ch(3, 16'hA5C1);
    set_ch(4, 16'h4444); set_ch(5, 16'h5555); set_ch(6, 16'h6789); set_ch(7, 16'hBEEF);
    select_display = 4'd3;
    auto_scan      = 1'b0;
    freeze         = 1'b0;
    reset          = 1'b1;

    // While reset is held, its outputs win over select_display=3.
    tick(); tick();
    push(0, BLANK, 8'hFF, 1'b0, "reset_state");

    // Manual selection, one-cycle latency right after reset release.
    reset = 1'b0;
    push(1, 32'h8892_C6F9, 8'hB0, 1'b0, "ch3_A5C1");
    tick();
    select_display = 4'd9;
    push(1, BLANK, 8'h90, 1'b0, "sel9_blank");
    tick();
    select_display = 4'd15;
    push(1, BLANK, 8'h8E, 1'b0, "sel15_blank");
    tick();
    select_display = 4'd7;
    push(1, seg_of(16'hBEEF, 0), 8'hF8, 1'b0, "ch7_last");
    tick();
    select_display = 4'd0;
    push(1, seg_of(16'h0F0F, 0), 8'hC0, 1'b0, "ch0_first");
    tick();
    select_display = 4'd6;
    push(1, seg_of(16'h6789, 0), 8'h82, 1'b0, "ch6_manual");
    tick();

    // Auto scan from 6: advance on every 4th edge, 6 -> 7 -> 0.
    auto_scan      = 1'b1;
    select_display = 4'd0;
    push(1, seg_of(16'h6789, 0), 8'h82, 1'b0, "auto_start6");
    push(3, seg_of(16'h6789, 0), 8'h82, 1'b0, "auto_dwell6");
    push(4, seg_of(16'hBEEF, 0), 8'hF8, 1'b0, "auto_adv7");
    push(7, seg_of(16'hBEEF, 0), 8'hF8, 1'b0, "auto_dwell7");
    push(8, seg_of(16'h0F0F, 0), 8'hC0, 1'b0, "auto_wrap0");
    repeat (8) tick();

    // Freeze rises on the terminal-count edge: index holds, old channel captured.
    repeat (3) tick();
    freeze = 1'b1;
    push(1, seg_of(16'h0F0F, 1), 8'hC0, 1'b1, "frz_terminal");
    tick();
    set_ch(0, 16'h0000);
    push(1, seg_of(16'h0F0F, 1), 8'hC0, 1'b1, "frz_hold_a");
    push(2, seg_of(16'h0F0F, 1), 8'hC0, 1'b1, "frz_hold_b");
    tick(); tick();
    // Prescaler was held at its terminal value, so resuming advances at once.
    freeze = 1'b0;
    push(1, seg_of(16'h1111, 0), 8'hF9, 1'b0, "unfrz_resume");
    tick();

    // Manual freeze on channel 2 while its data changes.
    auto_scan      = 1'b0;
    set_ch(0, 16'h0F0F);
    select_display = 4'd2;
    push(1, seg_of(16'h1234, 0), 8'hA4, 1'b0, "ch2_live");
    tick();
    freeze = 1'b1;
    push(1, seg_of(16'h1234, 1), 8'hA4, 1'b1, "frz_ch2");
    tick();
    set_ch(2, 16'hFFFF);
    push(1, seg_of(16'h1234, 1), 8'hA4, 1'b1, "frz_ch2_chg_a");
    tick();
    push(1, seg_of(16'h1234, 1), 8'hA4, 1'b1, "frz_ch2_chg_b");
    tick();
    freeze = 1'b0;
    push(1, 32'h8E8E_8E8E, 8'hA4, 1'b0, "unfrz_FFFF");
    tick();

    // Reset while frozen in auto mode.
    auto_scan = 1'b1;
    freeze    = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    push(1, BLANK, 8'hFF, 1'b0, "reset_midfreeze");
    tick();
    reset          = 1'b0;
    freeze         = 1'b0;
    select_display = 4'd5;
    push(1, seg_of(16'h0F0F, 0), 8'hC0, 1'b0, "post_reset_idx0");
    push(4, seg_of(16'h1111, 0), 8'hF9, 1'b0, "post_reset_adv1");
    repeat (4) tick();

    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expectations still pending, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/probe_display_mux.md
PROBE_DISPLAY_MUX -- requirements
Module: probe_display_mux

Interface
REQ-001 The block SHALL have parameter CH, default 8, the number of probe channels (2..16).
REQ-002 The block SHALL have parameter W, default 16, the channel width in bits (4..32, multiple of 4); localparam DIG = W/4 hex digits.
REQ-003 The block SHALL have parameter PRESCALE, default 50_000_000, the auto-scan dwell in clock cycles (>=2).
REQ-004 The block SHALL have port clock  in  1  system clock; one clock only.
REQ-005 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 The block SHALL have port ch_data  in  CH*W  packed probes; channel k = ch_data[k*W +: W].
REQ-007 The block SHALL have port select_display  in  4  rotary-switch channel index.
REQ-008 The block SHALL have port auto_scan  in  1  high = automatic channel rotation.
REQ-009 The block SHALL have port freeze  in  1  high = hold the displayed value.
REQ-010 The block SHALL have port seg_out  out  DIG*8  digit d = seg_out[d*8 +: 8], digit 0 least significant nibble.
REQ-011 The block SHALL have port index_out  out  8  seven-segment pattern of the current channel index.
REQ-012 The block SHALL have port frozen  out  1  freeze-hold active.

Function
REQ-013 Segment bytes SHALL be {dp,g,f,e,d,c,b,a}, active-low; blank = 8'hFF; hex 0..F in standard glyphs.
REQ-014 Manual mode (auto_scan=0): index register SHALL load select_display every cycle.
REQ-015 Manual mode with select_display >= CH: seg_out SHALL be all blank; index_out SHALL show the index glyph.
REQ-016 Auto mode (auto_scan=1): a prescale counter SHALL count 0..PRESCALE-1; index SHALL advance by 1 on the terminal count, wrapping CH-1 -> 0.
REQ-017 Entering auto mode SHALL start from the current index and clear the prescale counter; an index >= CH SHALL become 0 on the first advance.
REQ-018 Leaving auto mode SHALL return to manual loading on the next cycle; the prescale counter SHALL be cleared.
REQ-019 freeze rising (0 -> 1) SHALL capture the currently selected channel word into a snapshot register in the same cycle the edge is sampled.
REQ-020 While freeze=1: seg_out SHALL display the snapshot; index SHALL hold; the prescaler SHALL hold; frozen=1; the dp of digit 0 SHALL be lit (bit 7 = 0).
REQ-021 freeze falling SHALL resume live display and scanning on the next cycle; the prescaler SHALL resume from its held value.
REQ-022 Display latency SHALL be exactly 1 cycle: seg_out and index_out are registered from the index and data of the previous cycle.
REQ-023 If the auto advance and the freeze rise coincide, freeze SHALL win: the index does not advance; the snapshot takes the pre-advance channel.

Reset
REQ-024 On reset, the following SHALL hold: index=0; prescaler=0; snapshot=0; freeze edge detector=0; frozen=0; seg_out all 8'hFF; index_out=8'hFF.
REQ-025 Reset SHALL override all inputs, including mid-freeze and mid-dwell; the first non-blank output SHALL appear 1 cycle after reset deasserts.

Structure
REQ-026 A shared package SHALL hold SEG_BLANK, the 16-entry hex glyph table, and the segment bit-position constants.
REQ-027 One sub-module, hex7seg (4-bit nibble -> 8-bit pattern, combinational), SHALL be instantiated DIG+1 times.

Verification
REQ-028 CH=8, W=16: with reset, then select_display=3 and ch_data[3]=16'hA5C1, seg_out SHALL be {C1glyph order: digit3='A', 2='5', 1='C', 0='1'} one cycle later, with index_out='3'.
REQ-029 With select_display=9 (>=CH), seg_out SHALL be all 8'hFF one cycle later.
REQ-030 PRESCALE=4, auto_scan=1 from index 6: index SHALL go 6 -> 7 -> 0 at 4-cycle intervals (wrap).
REQ-031 With freeze=1 on channel 2 (value 16'h1234) while the data changes to 16'hFFFF, seg_out SHALL stay "1234" with digit 0 dp low and frozen=1; on freeze=0 it SHALL show "FFFF" one cycle later.
REQ-032 With freeze rising on the prescale terminal cycle, the index SHALL be unchanged and the snapshot SHALL hold the old channel's value.
REQ-033 With reset asserted while freeze=1 in auto mode, all outputs SHALL be blank and frozen=0 on the next edge; the index SHALL be 0.
